// File: rtl/sample_pipe_pkg.sv
// Shared helpers for sample_pipe: occupancy width, depth legality bound and parity.
package sample_pipe_pkg;

    localparam int MIN_DEPTH = 1;
    localparam int PAR_MAX_W = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Even-parity bit: set when the word holds an odd number of ones.
    function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sample_stage.sv
// One pipeline register: data plus its valid bit, with load enable, flush and reset.
module sample_stage #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Flush only kills the valid bit; data may still load since valid qualifies it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sample_pipe.sv
// sample_pipe: elastic DEPTH-stage retiming pipeline with flush and change detection.
// Stored-parity checking and the parity_err port exist only with SAMPLE_PIPE_PARITY_EN.
module sample_pipe
    import sample_pipe_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              din,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              dout,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic                          changed,
    output logic [clog2(DEPTH+1)-1:0]     occupancy
`ifdef SAMPLE_PIPE_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

`ifdef SAMPLE_PIPE_PARITY_EN
    localparam int PB = 1;
    localparam logic [WIDTH:0] RST_WORD = {parity_even(PAR_MAX_W'(RST_VAL)), RST_VAL};
`else
    localparam int PB = 0;
    localparam logic [WIDTH-1:0] RST_WORD = RST_VAL;
`endif
    localparam int SW    = WIDTH + PB;
    localparam int OCC_W = clog2(DEPTH + 1);

    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("sample_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [SW-1:0]    stage_data [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [SW-1:0]    din_s;
    logic             in_hs, out_hs;

    // Handshake: a word moves across an interface on a rising edge where valid
    // and ready are both high; valid never depends on ready, ready may depend on valid.
    assign in_ready  = rdy[0] & ~flush & ~rst;
    assign in_hs     = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_hs    = out_valid & out_ready;
    assign dout      = stage_data[DEPTH-1][WIDTH-1:0];

`ifdef SAMPLE_PIPE_PARITY_EN
    assign din_s = {parity_even(PAR_MAX_W'(din)), din};
`else
    assign din_s = din;
`endif

    // Stage i can advance if out_ready is high or any stage from i to the output
    // holds a bubble; unrolled this way to keep the chain free of self-feedback.
    always_comb begin
        logic all_full;
        all_full   = 1'b1;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            rdy[i]   = ~all_full | out_ready;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [SW-1:0] d_in;
        logic          v_in;
        if (i == 0) begin : g_head
            assign d_in = din_s;
            assign v_in = in_hs;
        end else begin : g_link
            assign d_in = stage_data[i-1];
            assign v_in = v[i-1];
        end
        sample_stage #(
            .WIDTH   (SW),
            .RST_VAL (RST_WORD)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (rdy[i]),
            .flush_i (flush),
            .valid_i (v_in),
            .data_i  (d_in),
            .valid_o (v[i]),
            .data_o  (stage_data[i])
        );
    end

    logic             changed_q, changed_d;
    logic [WIDTH-1:0] ref_q, ref_d;

    always_comb begin
        changed_d = 1'b0;
        ref_d     = ref_q;
        if (out_hs) begin
            changed_d = (dout != ref_q);
            ref_d     = dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
            ref_q     <= RST_VAL;
        end else begin
            changed_q <= changed_d;
            ref_q     <= ref_d;
        end
    end

    assign changed = changed_q;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

`ifdef SAMPLE_PIPE_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = 1'b0;
        if (out_hs) begin
            parity_err_d = stage_data[DEPTH-1][WIDTH] != parity_even(PAR_MAX_W'(dout));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sample_pipe.sv
// Bench for sample_pipe: three instances (4x2, 8x1, 8x5) against a queue-based model.
// Parity-error checks are included when SAMPLE_PIPE_PARITY_EN is defined.
module tb_sample_pipe;

    logic       clk;
    logic [7:0] din [3];
    logic [2:0] in_valid, out_ready, flush, rst;
    logic [2:0] in_ready_w, out_valid_w, changed_w;
    logic [3:0] dout_a;
    logic [7:0] dout_b, dout_c;
    logic [1:0] occ_a;
    logic [0:0] occ_b;
    logic [2:0] occ_c;
    logic [7:0] dout_w [3];
    logic [2:0] occ_w [3];
`ifdef SAMPLE_PIPE_PARITY_EN
    logic [2:0] perr_w;
`endif

    assign dout_w[0] = {4'h0, dout_a};
    assign dout_w[1] = dout_b;
    assign dout_w[2] = dout_c;
    assign occ_w[0]  = {1'b0, occ_a};
    assign occ_w[1]  = {2'b00, occ_b};
    assign occ_w[2]  = occ_c;

    sample_pipe #(.WIDTH(4), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst[0]), .din(din[0][3:0]), .in_valid(in_valid[0]),
        .in_ready(in_ready_w[0]), .dout(dout_a), .out_valid(out_valid_w[0]),
        .out_ready(out_ready[0]), .flush(flush[0]), .changed(changed_w[0]),
        .occupancy(occ_a)
`ifdef SAMPLE_PIPE_PARITY_EN
        , .parity_err(perr_w[0])
`endif
    );

    sample_pipe #(.WIDTH(8), .DEPTH(1)) dut_b (
        .clk(clk), .rst(rst[1]), .din(din[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready_w[1]), .dout(dout_b), .out_valid(out_valid_w[1]),
        .out_ready(out_ready[1]), .flush(flush[1]), .changed(changed_w[1]),
        .occupancy(occ_b)
`ifdef SAMPLE_PIPE_PARITY_EN
        , .parity_err(perr_w[1])
`endif
    );

    sample_pipe #(.WIDTH(8), .DEPTH(5)) dut_c (
        .clk(clk), .rst(rst[2]), .din(din[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready_w[2]), .dout(dout_c), .out_valid(out_valid_w[2]),
        .out_ready(out_ready[2]), .flush(flush[2]), .changed(changed_w[2]),
        .occupancy(occ_c)
`ifdef SAMPLE_PIPE_PARITY_EN
        , .parity_err(perr_w[2])
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [7:0] exp_q0 [$], exp_q1 [$], exp_q2 [$];
    int         t_q0 [$], t_q1 [$], t_q2 [$];
    logic [7:0] ref_m [3];
    logic [2:0] exp_chg, exp_perr;
    int         cycle, n_cmp, n_err;
    bit         lat_chk, perr_arm;

    function automatic int dep(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic [7:0] mask(input int k);
        return (k == 0) ? 8'h0F : 8'hFF;
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [7:0] q_front(input int k);
        case (k)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic int q_tfront(input int k);
        case (k)
            0:       return t_q0[0];
            1:       return t_q1[0];
            default: return t_q2[0];
        endcase
    endfunction

    task automatic q_push(input int k, input logic [7:0] w, input int t);
        case (k)
            0:       begin exp_q0.push_back(w); t_q0.push_back(t); end
            1:       begin exp_q1.push_back(w); t_q1.push_back(t); end
            default: begin exp_q2.push_back(w); t_q2.push_back(t); end
        endcase
    endtask

    task automatic q_pop(input int k, output logic [7:0] w);
        case (k)
            0:       begin w = exp_q0.pop_front(); void'(t_q0.pop_front()); end
            1:       begin w = exp_q1.pop_front(); void'(t_q1.pop_front()); end
            default: begin w = exp_q2.pop_front(); void'(t_q2.pop_front()); end
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0:       begin exp_q0.delete(); t_q0.delete(); end
            1:       begin exp_q1.delete(); t_q1.delete(); end
            default: begin exp_q2.delete(); t_q2.delete(); end
        endcase
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h (cycle %0d)", tag, k, obs, exp, cycle);
        end
    endtask

    // driver: sample at negedge, advance one edge, update the model, check registered outputs
    task automatic tick();
        logic [2:0] in_hs, out_hs;
        logic [7:0] w;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_hs[k]  = in_valid[k] & in_ready_w[k];
            out_hs[k] = out_valid_w[k] & out_ready[k] & ~rst[k];
            if (!rst[k]) begin
                chk("in_ready", k, 32'(in_ready_w[k]),
                    32'(~flush[k] & (out_ready[k] | (q_size(k) < dep(k)))));
                if (q_size(k) == 0) chk("out_valid_empty", k, 32'(out_valid_w[k]), 32'd0);
                if (out_hs[k] && q_size(k) > 0) begin
                    chk("dout", k, 32'(dout_w[k]), 32'(q_front(k)));
                    if (lat_chk) chk("latency", k, 32'(cycle - q_tfront(k)), 32'(dep(k) - 1));
                end
            end
        end
        @(posedge clk);
        cycle++;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_chg[k]  = 1'b0;
            exp_perr[k] = 1'b0;
            if (rst[k]) begin
                q_clear(k);
                ref_m[k] = 8'h00;
            end else begin
                if (out_hs[k] && q_size(k) > 0) begin
                    q_pop(k, w);
                    exp_chg[k] = (w != ref_m[k]);
                    ref_m[k]   = w;
                    if (k == 0 && perr_arm) exp_perr[k] = 1'b1;
                end
                if (flush[k]) q_clear(k);
                if (in_hs[k]) q_push(k, din[k] & mask(k), cycle);
            end
            chk("changed", k, 32'(changed_w[k]), 32'(exp_chg[k]));
            chk("occupancy", k, 32'(occ_w[k]), 32'(q_size(k)));
            chk("occ_bound", k, 32'(occ_w[k] <= 3'(dep(k))), 32'd1);
`ifdef SAMPLE_PIPE_PARITY_EN
            chk("parity_err", k, 32'(perr_w[k]), 32'(exp_perr[k]));
`endif
        end
    endtask

    logic [7:0] seq [4];

    initial begin
        n_cmp = 0; n_err = 0; cycle = 0; lat_chk = 1'b0; perr_arm = 1'b0;
        exp_chg = '0; exp_perr = '0;
        for (int k = 0; k < 3; k++) begin
            din[k] = 8'h00; ref_m[k] = 8'h00;
        end
        in_valid = '0; out_ready = '0; flush = '0; rst = 3'b111;

        // reset for two cycles, then reset-state checks
        tick();
        tick();
        rst = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", k, 32'(out_valid_w[k]), 32'd0);
            chk("rst_dout", k, 32'(dout_w[k]), 32'd0);
            chk("rst_changed", k, 32'(changed_w[k]), 32'd0);
            chk("rst_occupancy", k, 32'(occ_w[k]), 32'd0);
            chk("rst_in_ready", k, 32'(in_ready_w[k]), 32'd1);
        end

        // back-to-back stream 5, A, A, 3 with no stalls; latency checked on all instances
        seq = '{8'h05, 8'h0A, 8'h0A, 8'h03};
        out_ready = 3'b111;
        lat_chk   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din[0] = seq[i];
            din[1] = 8'($urandom);
            din[2] = 8'($urandom);
            in_valid = 3'b111;
            tick();
        end
        in_valid = '0;
        for (int i = 0; i < 7; i++) tick();
        lat_chk = 1'b0;

        // backpressure on the 4x2 instance
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        din[0] = 8'h01; tick();
        din[0] = 8'h02; tick();
        din[0] = 8'h03;
        #1;
        chk("bp_full_in_ready", 0, 32'(in_ready_w[0]), 32'd0);
        chk("bp_full_occupancy", 0, 32'(occ_w[0]), 32'd2);
        tick();
        out_ready[0] = 1'b1;
        #1;
        chk("bp_release_in_ready", 0, 32'(in_ready_w[0]), 32'd1);
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // flush with two words in flight and 4'hC offered
        in_valid[0] = 1'b1;
        din[0] = 8'h07; tick();
        din[0] = 8'h08; tick();
        din[0] = 8'h0C;
        flush[0] = 1'b1;
        #1;
        chk("flush_in_ready", 0, 32'(in_ready_w[0]), 32'd0);
        tick();
        flush[0] = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        chk("flush_out_valid", 0, 32'(out_valid_w[0]), 32'd0);
        chk("flush_occupancy", 0, 32'(occ_w[0]), 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // reset in the middle of a full pipeline with out_ready high
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        din[0] = 8'h04; tick();
        din[0] = 8'h0E; tick();
        out_ready[0] = 1'b1;
        din[0] = 8'h09;
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        chk("midrst_out_valid", 0, 32'(out_valid_w[0]), 32'd0);
        chk("midrst_dout", 0, 32'(dout_w[0]), 32'd0);
        chk("midrst_changed", 0, 32'(changed_w[0]), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // randomized traffic on all instances
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 3; k++) begin
                din[k]       = 8'($urandom) & mask(k);
                in_valid[k]  = 1'($urandom_range(0, 1));
                out_ready[k] = ($urandom_range(0, 3) != 0);
                flush[k]     = ($urandom_range(0, 49) == 0);
            end
            tick();
        end
        in_valid = '0; flush = '0; out_ready = 3'b111;
        for (int i = 0; i < 8; i++) tick();
        for (int k = 0; k < 3; k++) chk("drain_empty", k, 32'(q_size(k)), 32'd0);

`ifdef SAMPLE_PIPE_PARITY_EN
        // corrupt one stored data bit in the output stage of the 4x2 instance
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        din[0] = 8'h06; tick();
        in_valid[0] = 1'b0;
        tick();
        force dut_a.g_stage[1].u_stage.data_q = 5'b0_0111;
        exp_q0[0] = 8'h07;
        perr_arm = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        perr_arm = 1'b0;
        release dut_a.g_stage[1].u_stage.data_q;
        for (int i = 0; i < 3; i++) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_pipe.md
Name: sample_pipe

Overview:
- Parametrised, elastic sampling pipeline: DEPTH register stages of WIDTH bits, each stage carrying its own valid bit.
- Replaces the fixed 4-bit two-register sampler with a valid/ready handshake, backpressure, flush and change detection.
- Sits between a producer and a consumer inside one clock domain.
- Used wherever data must be retimed by a known number of cycles without losing words when the consumer stalls.

Parameters:
- WIDTH, 4, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1); no-stall latency in cycles.
- RST_VAL, {WIDTH{1'b0}}, reset value of every data stage and of the change-detect reference.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  input word.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  pipeline accepts din this cycle.
- dout  output  WIDTH  data of the last stage.
- out_valid  output  1  dout is valid.
- out_ready  input  1  consumer accepts dout this cycle.
- flush  input  1  discard all in-flight words.
- changed  output  1  one-cycle pulse: last delivered word differed from the one before it.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset is synchronous and active-high: one clock, rst sampled on the rising edge of clk.
- Reset values:
  - all stage valids = 0, all stage data = RST_VAL;
  - out_valid = 0, dout = RST_VAL;
  - changed = 0, occupancy = 0;
  - change reference register = RST_VAL.
- Stages are numbered 0 (input) to DEPTH-1 (output).
- Ready chain:
  - rdy[DEPTH] = out_ready;
  - rdy[i] = ~v[i] | rdy[i+1];
  - in_ready = rdy[0] & ~flush & ~rst.
  - This is a combinational out_ready -> in_ready path; it is allowed and must contain no latches.
- Stage update:
  - When rdy[i] = 1, stage i loads data[i-1] and v[i-1]. Stage 0 loads din and in_valid & in_ready.
  - When rdy[i] = 0, stage i holds.
  - Data registers may load on every rdy cycle regardless of valid; only valid qualifies data.
- Handshakes:
  - Input handshake = in_valid & in_ready. Output handshake = out_valid & out_ready.
  - Order is strictly preserved; no word is duplicated or dropped except by flush or rst.
- Latency: a word accepted at edge N is on dout with out_valid = 1 after edge N+DEPTH-1, i.e. DEPTH cycles, when nothing stalls.
- Throughput: one word per cycle while out_ready = 1.
- Full: all v = 1 and out_ready = 0 gives in_ready = 0. With all stages full and out_ready = 1, a new word is accepted in the same cycle.
- Empty: out_valid = 0. dout holds the last stage data and is don't-care.
- Flush:
  - On an edge with flush = 1, every valid bit clears; data is unaffected.
  - in_ready = 0 during flush, so an input word offered that cycle is not taken.
  - An output handshake in the flush cycle still counts as delivered.
  - changed is still updated for that handshake.
- rst takes priority over flush and over both handshakes.
- changed:
  - Registered. On each output handshake, compare dout with the reference register.
  - changed <= (dout != ref), then ref <= dout.
  - Without a handshake, changed <= 0.
- occupancy: the popcount of v[], derived combinationally from registers only.

Optional Feature:
- Macro: SAMPLE_PIPE_PARITY_EN.
- Defined:
  - Each stage stores an extra even-parity bit computed from din at acceptance.
  - A registered output port parity_err (1 bit) pulses for one cycle after any output handshake whose stored parity mismatches the recomputed parity of dout.
  - Reset value of parity_err is 0.
  - Port exists only when the macro is defined.
- Undefined: no parity storage, no parity_err port; behaviour is otherwise identical.

Decomposition:
- Shared package sample_pipe_pkg holds:
  - function clog2 for the occupancy width;
  - a DEPTH >= 1 legality check constant;
  - a parity helper function.
- One sub-module is natural: sample_stage, a single valid/data register with load enable, flush and reset, instantiated DEPTH times by a generate loop.
- The top holds the ready chain, the change detector and occupancy.

Test Plan:
- Reset and drain, WIDTH=4, DEPTH=2, out_ready=1:
  - stimulus: assert rst 2 cycles, then stream 4'h5, 4'hA, 4'hA, 4'h3 back-to-back;
  - response: each word appears 2 cycles after acceptance in order 5, A, A, 3; changed pulses 1, 1, 0, 1 one cycle after each handshake (first compare against RST_VAL 0).
- Backpressure:
  - stimulus: out_ready=0, offer 3 words;
  - response: 2 accepted, then in_ready=0 and occupancy=2. Raise out_ready: the third word is accepted in the same cycle, no loss, order kept.
- Flush mid-stream:
  - stimulus: with 2 words in flight, pulse flush while in_valid=1 and din=4'hC;
  - response: next cycle occupancy=0 and out_valid=0; 4'hC is not delivered.
- Reset mid-operation:
  - stimulus: full pipeline, out_ready=1, assert rst for 1 cycle;
  - response: next cycle out_valid=0, dout=RST_VAL, changed=0, and no handshake counted in the reset cycle.
- DEPTH=1 and DEPTH=5, WIDTH=8:
  - stimulus: random in_valid and out_ready for 1000 cycles against a scoreboard queue;
  - response: exact ordered match; no-stall latency equals DEPTH; occupancy never exceeds DEPTH.
- SAMPLE_PIPE_PARITY_EN defined:
  - stimulus: force-flip one stored data bit in stage DEPTH-1;
  - response: parity_err=1 for exactly one cycle after that word's handshake, otherwise 0.
